// File: rtl/dpll_pkg.sv
// Shared DPLL definitions: phase-error format limits and the
// phase detector FSM states, used by the detector and loop filter.
package dpll_pkg;

    localparam int DPD_W     = 20;
    localparam int FRAC_W    = 11;
    localparam int DLF_OUT_W = 16;

    localparam int DPD_MAX = 524287;
    localparam int DPD_MIN = -524288;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        TRACK
    } dpd_state_t;

endpackage

// File: rtl/dpll_sat.sv
// Generic signed saturator: clamps a wide signed value into OUT_W bits.
// Ports: din (IN_W signed), dout (OUT_W signed), clip (1 = value clamped).
module dpll_sat #(
    parameter int IN_W  = 27,
    parameter int OUT_W = 20
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clip
);

    localparam logic signed [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OMIN = {1'b1, {(OUT_W-1){1'b0}}};

    // Value fits iff every bit from the output sign bit upward matches.
    logic [IN_W-OUT_W:0] hi_bits;

    assign hi_bits = din[IN_W-1:OUT_W-1];

    always_comb begin
        clip = !((&hi_bits) || !(|hi_bits));
        dout = din[OUT_W-1:0];
        if (clip) begin
            dout = din[IN_W-1] ? OMIN : OMAX;
        end
    end

endmodule

// File: rtl/dpd_phase_err.sv
// Digital phase detector: reference phase accumulator minus sampled
// variable phase {dco_cnt, tdc_frac}, saturated to signed 9.11.
// Ports: clk, rst (sync, high), enable, fcw, dco_cnt, tdc_frac,
// tdc_valid in; dpd_out, dpd_valid, dpd_sat, lock out.
module dpd_phase_err
    import dpll_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int LOCK_THR = 64,
    parameter int LOCK_N   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [19:0]             fcw,
    input  logic [CNT_W-1:0]        dco_cnt,
    input  logic [FRAC_W-1:0]       tdc_frac,
    input  logic                    tdc_valid,
    output logic signed [DPD_W-1:0] dpd_out,
    output logic                    dpd_valid,
    output logic                    dpd_sat,
    output logic                    lock
);

    localparam int PHASE_W = CNT_W + FRAC_W;
    localparam int LCW     = $clog2(LOCK_N + 1);

    dpd_state_t state, state_nx;

    logic [PHASE_W-1:0]        ref_ph;
    logic [PHASE_W-1:0]        r_v;
    logic [PHASE_W-1:0]        ref_adv;
    logic signed [PHASE_W-1:0] err_raw;
    logic                      v1;
    logic signed [DPD_W-1:0]   sat_out;
    logic                      sat_clip;
    logic [DPD_W:0]            err_ext;
    logic [DPD_W:0]            err_abs;
    logic                      in_win;
    logic [LCW-1:0]            lock_cnt;

    assign r_v     = {dco_cnt, tdc_frac};
    assign ref_adv = ref_ph + PHASE_W'(fcw);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (enable) state_nx = ALIGN;
            ALIGN:   if (tdc_valid) state_nx = TRACK;
            TRACK:   state_nx = TRACK;
            default: state_nx = IDLE;
        endcase
        if (!enable) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Stage 1: reference accumulator and raw modular phase difference.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            ref_ph  <= '0;
            err_raw <= '0;
            v1      <= 1'b0;
        end else begin
            v1 <= 1'b0;
            case (state)
                ALIGN: begin
                    if (tdc_valid) ref_ph <= r_v;
                end
                TRACK: begin
                    ref_ph <= ref_adv;
                    if (tdc_valid) begin
                        err_raw <= ref_adv - r_v;
                        v1      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    dpll_sat #(
        .IN_W  (PHASE_W),
        .OUT_W (DPD_W)
    ) u_sat (
        .din  (err_raw),
        .dout (sat_out),
        .clip (sat_clip)
    );

    // Magnitude in one extra bit so the most negative value cannot wrap.
    assign err_ext = {sat_out[DPD_W-1], sat_out};
    assign err_abs = err_ext[DPD_W] ? (~err_ext + 1'b1) : err_ext;
    assign in_win  = !sat_clip && (err_abs <= (DPD_W+1)'(LOCK_THR));

    // Stage 2: output register and lock qualification.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            dpd_out   <= '0;
            dpd_valid <= 1'b0;
            dpd_sat   <= 1'b0;
            lock      <= 1'b0;
            lock_cnt  <= '0;
        end else begin
            dpd_valid <= v1;
            if (v1) begin
                dpd_out <= sat_out;
                dpd_sat <= sat_clip;
                if (in_win) begin
                    if (lock_cnt != LCW'(LOCK_N)) begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                    if (lock_cnt >= LCW'(LOCK_N - 1)) begin
                        lock <= 1'b1;
                    end
                end else begin
                    lock_cnt <= '0;
                    lock     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dpd_phase_err.sv
// Scoreboard bench for dpd_phase_err: directed samples push expected
// results; a negedge monitor pops and compares on each dpd_valid.
module tb_dpd_phase_err;
    import dpll_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic [19:0]        fcw;
    logic [15:0]        dco_cnt;
    logic [10:0]        tdc_frac;
    logic               tdc_valid;
    logic signed [19:0] dpd_out;
    logic               dpd_valid;
    logic               dpd_sat;
    logic               lock;

    typedef struct {
        logic signed [19:0] out;
        logic               sat;
        logic               lk;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    logic [26:0] tb_ref;
    bit          trk;

    always #5 clk = ~clk;

    dpd_phase_err #(
        .CNT_W    (16),
        .LOCK_THR (64),
        .LOCK_N   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .fcw       (fcw),
        .dco_cnt   (dco_cnt),
        .tdc_frac  (tdc_frac),
        .tdc_valid (tdc_valid),
        .dpd_out   (dpd_out),
        .dpd_valid (dpd_valid),
        .dpd_sat   (dpd_sat),
        .lock      (lock)
    );

    always @(negedge clk) begin
        if (dpd_valid === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL strobe: unexpected dpd_valid, dpd_out=%0d",
                         dpd_out);
            end else begin
                mon_e = sb.pop_front();
                if (dpd_out !== mon_e.out || dpd_sat !== mon_e.sat ||
                    lock !== mon_e.lk) begin
                    n_err++;
                    $display("FAIL vec%0d: got out=%0d sat=%b lock=%b, need out=%0d sat=%b lock=%b",
                             n_vec, dpd_out, dpd_sat, lock,
                             mon_e.out, mon_e.sat, mon_e.lk);
                end
            end
        end
    end

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, need %0d", nm, act, exp);
        end
    endtask

    task automatic tick(bit v, logic [15:0] c, logic [10:0] f);
        tdc_valid = v;
        dco_cnt   = c;
        tdc_frac  = f;
        @(posedge clk);
        #1;
        tdc_valid = 1'b0;
    endtask

    task automatic gap(int n);
        repeat (n) begin
            tick(1'b0, 16'd0, 11'd0);
            if (trk) tb_ref = tb_ref + 27'(fcw);
        end
    endtask

    task automatic align(logic [15:0] c, logic [10:0] f);
        tick(1'b1, c, f);
        tb_ref = {c, f};
        trk    = 1'b1;
    endtask

    task automatic samp_raw(logic [15:0] c, logic [10:0] f,
                            int eo, bit es, bit el, bit push);
        exp_t e;
        e.out = 20'(eo);
        e.sat = es;
        e.lk  = el;
        if (push) sb.push_back(e);
        tick(1'b1, c, f);
        tb_ref = tb_ref + 27'(fcw);
    endtask

    // Build a sample whose true error against the reference is err.
    task automatic samp_err(int err, int eo, bit es, bit el, bit push);
        logic [26:0] ph;
        ph = tb_ref + 27'(fcw) - 27'(err);
        samp_raw(ph[26:11], ph[10:0], eo, es, el, push);
    endtask

    task automatic chk_zero(string nm);
        chk({nm, "_out"},   int'(dpd_out),   0);
        chk({nm, "_valid"}, int'(dpd_valid), 0);
        chk({nm, "_sat"},   int'(dpd_sat),   0);
        chk({nm, "_lock"},  int'(lock),      0);
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        fcw       = 20'd20480;
        dco_cnt   = '0;
        tdc_frac  = '0;
        tdc_valid = 1'b0;
        tb_ref    = '0;
        trk       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");

        rst    = 1'b0;
        enable = 1'b1;
        gap(1);
        align(16'd100, 11'd0);
        samp_raw(16'd110, 11'd0,    0,    1'b0, 1'b0, 1'b1);
        samp_raw(16'd119, 11'd1024, 1024, 1'b0, 1'b0, 1'b1);
        samp_raw(16'd130, 11'd512,  -512, 1'b0, 1'b0, 1'b1);
        gap(3);
        chk("hold_out", int'(dpd_out), -512);
        chk("hold_valid", int'(dpd_valid), 0);

        samp_err(-614400, DPD_MIN, 1'b1, 1'b0, 1'b1);
        gap(3);
        chk("hold_sat", int'(dpd_sat), 1);
        chk("hold_sat_out", int'(dpd_out), DPD_MIN);

        for (int i = 0; i < 16; i++) begin
            samp_err(32, 32, 1'b0, (i == 15), 1'b1);
            if (i == 3 || i == 9) gap(2);
        end
        samp_err(0,   0,   1'b0, 1'b1, 1'b1);
        samp_err(100, 100, 1'b0, 1'b0, 1'b1);
        samp_err(65,  65,  1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            samp_err(-64, -64, 1'b0, (i == 15), 1'b1);
        end
        gap(3);
        chk("lock_held", int'(lock), 1);

        samp_err(0, 0, 1'b0, 1'b0, 1'b0);
        enable = 1'b0;
        tick(1'b0, 16'd0, 11'd0);
        trk = 1'b0;
        chk_zero("en_drop");
        gap(1);

        enable = 1'b1;
        gap(1);
        align(16'd65530, 11'd0);
        samp_raw(16'd4, 11'd0, 0, 1'b0, 1'b0, 1'b1);
        samp_err(40, 40, 1'b0, 1'b0, 1'b1);
        gap(3);
        chk("wrap_hold", int'(dpd_out), 40);

        samp_err(8, 8, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick(1'b0, 16'd0, 11'd0);
        trk = 1'b0;
        chk_zero("rst_mid");
        rst = 1'b0;
        gap(1);
        align(16'd5000, 11'd100);
        samp_err(16, 16, 1'b0, 1'b0, 1'b1);
        gap(4);
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
